// File: rtl/vga_timing_pkg.sv
// Shared raster timing types, default 640x480@60 timing and counter-width helpers
// for the VGA scan-position generator.
package vga_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2, bp: 33};

  function automatic int total(vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic int cw(int h, int v);
    return $clog2((h > v) ? h : v);
  endfunction

  // Index width that stays at least one bit for degenerate sizes of 1.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/vga_scan_timing_if.sv
// Scan-position bundle from the raster generator to the framebuffer/font stages;
// the consumer drives the enable (pixel-clock stall).
interface vga_scan_timing_if #(
  parameter int CW  = 10,
  parameter int GCW = 3,
  parameter int GRW = 3
);
  logic           enable;
  logic [CW-1:0]  col;
  logic [CW-1:0]  row;
  logic [CW-1:0]  win_row;
  logic           is_blank;
  logic           is_border;
  logic [GCW-1:0] glyph_col;
  logic [GRW-1:0] glyph_row;
  logic [7:0]     char_col;
  logic [7:0]     char_row;
  logic           vga_hsync;
  logic           vga_vsync;
  logic           blank_d;
  logic           line_start;
  logic           frame_start;
  logic           blink;

  modport master (
    input  enable,
    output col, row, win_row, is_blank, is_border, glyph_col, glyph_row,
           char_col, char_row, vga_hsync, vga_vsync, blank_d,
           line_start, frame_start, blink
  );

  modport slave (
    output enable,
    input  col, row, win_row, is_blank, is_border, glyph_col, glyph_row,
           char_col, char_row, vga_hsync, vga_vsync, blank_d,
           line_start, frame_start, blink
  );
endinterface

// File: rtl/vga_sync_delay.sv
// Enabled shift register that lags sync/blank behind the scan position so they line up
// with the framebuffer -> font -> colour pipeline.
module vga_sync_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// Parametrised raster timing generator: raw col/row, blank/border flags, text-cell
// coordinates with line repeat, delayed syncs, frame/line strobes and cursor blink.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_640X480_H.active,
  parameter int H_FP         = VGA_640X480_H.fp,
  parameter int H_SYNC       = VGA_640X480_H.sync,
  parameter int H_BP         = VGA_640X480_H.bp,
  parameter int V_ACTIVE     = VGA_640X480_V.active,
  parameter int V_FP         = VGA_640X480_V.fp,
  parameter int V_SYNC       = VGA_640X480_V.sync,
  parameter int V_BP         = VGA_640X480_V.bp,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int V_BORDER     = 40,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 8,
  parameter int ROW_REPEAT   = 2,
  parameter int PIPE_DEPTH   = 3,
  parameter int BLINK_FRAMES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_scan_timing_if.master bus
);

  localparam vga_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int H_TOTAL  = total(H_T);
  localparam int V_TOTAL  = total(V_T);
  localparam int CW       = cw(H_TOTAL, V_TOTAL);
  localparam int GCW      = idx_w(GLYPH_W);
  localparam int GRW      = idx_w(GLYPH_H);
  localparam int RW       = idx_w(ROW_REPEAT);
  localparam int FW       = idx_w(BLINK_FRAMES);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int WIN_END  = V_ACTIVE - V_BORDER;

  localparam logic [CW-1:0]  H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]  V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]  BORDER_OFS  = CW'(V_BORDER);
  localparam logic [CW-1:0]  WIN_ROW_RST = CW'(-V_BORDER);
  localparam logic [GCW-1:0] GCOL_LAST   = GCW'(GLYPH_W - 1);
  localparam logic [GRW-1:0] GROW_LAST   = GRW'(GLYPH_H - 1);
  localparam logic [RW-1:0]  REP_LAST    = RW'(ROW_REPEAT - 1);
  localparam logic [FW-1:0]  FCNT_LAST   = FW'(BLINK_FRAMES - 1);
  localparam logic           BORDER_RST  = (V_BORDER > 0);

  if (2 * V_BORDER >= V_ACTIVE) begin : g_bad_border
    $error("vga_scan_timing: 2*V_BORDER must be less than V_ACTIVE");
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
    $error("vga_scan_timing: PIPE_DEPTH must be within 1..8");
  end
  if (!is_pow2(GLYPH_W) || !is_pow2(GLYPH_H)) begin : g_bad_glyph
    $error("vga_scan_timing: GLYPH_W and GLYPH_H must be powers of two");
  end
  if (ROW_REPEAT < 1 || BLINK_FRAMES < 1 || V_BORDER < 0) begin : g_bad_misc
    $error("vga_scan_timing: ROW_REPEAT and BLINK_FRAMES must be >= 1, V_BORDER >= 0");
  end

  logic [CW-1:0]  col_q, row_q, win_row_q;
  logic [CW-1:0]  col_n, row_n, win_row_n;
  logic           blank_q, border_q, blank_n, border_n;
  logic [GCW-1:0] gcol_q, gcol_n;
  logic [GRW-1:0] grow_q, grow_n;
  logic [7:0]     ccol_q, ccol_n, crow_q, crow_n;
  logic [RW-1:0]  rep_q, rep_n;
  logic [FW-1:0]  fcnt_q, fcnt_n;
  logic           blink_q, blink_n;
  logic           ls_q, ls_n, fs_q, fs_n;
  logic           started_q, started_n;
  logic           in_window, col_active;
  logic           hs_lvl, vs_lvl;
  logic [2:0]     pipe_q;

  assign in_window  = (int'(row_q) >= V_BORDER) && (int'(row_q) < WIN_END);
  assign col_active = int'(col_q) < H_ACTIVE;

  // The first enabled cycle after reset presents pixel (0,0) with both strobes
  // instead of advancing, so consumers always see a frame_start before pixel data.
  always_comb begin
    col_n     = col_q;
    row_n     = row_q;
    gcol_n    = gcol_q;
    ccol_n    = ccol_q;
    rep_n     = rep_q;
    grow_n    = grow_q;
    crow_n    = crow_q;
    fcnt_n    = fcnt_q;
    blink_n   = blink_q;
    started_n = started_q;
    ls_n      = 1'b0;
    fs_n      = 1'b0;
    if (bus.enable) begin
      if (!started_q) begin
        started_n = 1'b1;
        ls_n      = 1'b1;
        fs_n      = 1'b1;
      end else if (col_q == H_LAST) begin
        col_n  = '0;
        gcol_n = '0;
        ccol_n = '0;
        ls_n   = 1'b1;
        if (row_q == V_LAST) begin
          row_n  = '0;
          rep_n  = '0;
          grow_n = '0;
          crow_n = '0;
          fs_n   = 1'b1;
        end else begin
          row_n = row_q + CW'(1);
          if (in_window) begin
            if (rep_q == REP_LAST) begin
              rep_n = '0;
              if (grow_q == GROW_LAST) begin
                grow_n = '0;
                crow_n = crow_q + 8'd1;
              end else begin
                grow_n = grow_q + GRW'(1);
              end
            end else begin
              rep_n = rep_q + RW'(1);
            end
          end
        end
      end else begin
        col_n = col_q + CW'(1);
        if (col_active) begin
          if (gcol_q == GCOL_LAST) begin
            gcol_n = '0;
            ccol_n = ccol_q + 8'd1;
          end else begin
            gcol_n = gcol_q + GCW'(1);
          end
        end
      end
      if (fs_n) begin
        if (fcnt_q == FCNT_LAST) begin
          fcnt_n  = '0;
          blink_n = !blink_q;
        end else begin
          fcnt_n = fcnt_q + FW'(1);
        end
      end
    end
    blank_n   = (int'(col_n) >= H_ACTIVE) || (int'(row_n) >= V_ACTIVE);
    border_n  = !blank_n && ((int'(row_n) < V_BORDER) || (int'(row_n) >= WIN_END));
    win_row_n = row_n - BORDER_OFS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q     <= '0;
      row_q     <= '0;
      win_row_q <= WIN_ROW_RST;
      blank_q   <= 1'b0;
      border_q  <= BORDER_RST;
      gcol_q    <= '0;
      ccol_q    <= '0;
      rep_q     <= '0;
      grow_q    <= '0;
      crow_q    <= '0;
      fcnt_q    <= '0;
      blink_q   <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      started_q <= 1'b0;
    end else begin
      col_q     <= col_n;
      row_q     <= row_n;
      win_row_q <= win_row_n;
      blank_q   <= blank_n;
      border_q  <= border_n;
      gcol_q    <= gcol_n;
      ccol_q    <= ccol_n;
      rep_q     <= rep_n;
      grow_q    <= grow_n;
      crow_q    <= crow_n;
      fcnt_q    <= fcnt_n;
      blink_q   <= blink_n;
      ls_q      <= ls_n;
      fs_q      <= fs_n;
      started_q <= started_n;
    end
  end

  // Undelayed sync levels come straight from the registered position.
  assign hs_lvl = ((int'(col_q) >= HS_START) && (int'(col_q) < HS_END)) ? HSYNC_POL : !HSYNC_POL;
  assign vs_lvl = ((int'(row_q) >= VS_START) && (int'(row_q) < VS_END)) ? VSYNC_POL : !VSYNC_POL;

  vga_sync_delay #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DEPTH),
    .RESET_VAL ({!HSYNC_POL, !VSYNC_POL, 1'b1})
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (bus.enable),
    .din   ({hs_lvl, vs_lvl, blank_q | border_q}),
    .dout  (pipe_q)
  );

  assign bus.col         = col_q;
  assign bus.row         = row_q;
  assign bus.win_row     = win_row_q;
  assign bus.is_blank    = blank_q;
  assign bus.is_border   = border_q;
  assign bus.glyph_col   = gcol_q;
  assign bus.glyph_row   = grow_q;
  assign bus.char_col    = ccol_q;
  assign bus.char_row    = crow_q;
  assign bus.vga_hsync   = pipe_q[2];
  assign bus.vga_vsync   = pipe_q[1];
  assign bus.blank_d     = pipe_q[0];
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.blink       = blink_q;

endmodule
